// File: rtl/gen_posic_random_rango.sv
// Position generator: free-running LCG, rejection sampling into [POS_MIN, POS_MAX], bounded fallback after MAX_INTENTOS tries.
// Latency is 2..MAX_INTENTOS+1 edges from pedir to valido; the result is held stable until tomar, and pedir is ignored while busy.
module gen_posic_random_rango #(
    parameter int BITS_ESTADO       = 16,
    parameter int BITS_RESULTADO    = 11,
    parameter int SEMILLA           = 1,
    parameter int MULTIPLICADOR     = 25173,
    parameter int CONSTANTE_ADITIVA = 13849,
    parameter int POS_MIN           = 0,
    parameter int POS_MAX           = 639,
    parameter int MAX_INTENTOS      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pedir,
    input  logic                      tomar,
    input  logic                      carga_semilla,
    input  logic [BITS_ESTADO-1:0]    semilla,
    output logic [BITS_RESULTADO-1:0] dato,
    output logic                      valido,
    output logic                      ocupado,
    output logic                      forzado
);

    typedef enum logic [1:0] {REPOSO, BUSCANDO, LISTO} fsm_t;

    localparam int BITS_INT = (MAX_INTENTOS > 1) ? $clog2(MAX_INTENTOS) : 1;
    localparam logic [BITS_ESTADO-1:0]    MULT     = BITS_ESTADO'(MULTIPLICADOR);
    localparam logic [2*BITS_ESTADO-1:0]  INC      = (2*BITS_ESTADO)'(CONSTANTE_ADITIVA);
    localparam logic [BITS_ESTADO-1:0]    INICIAL  = BITS_ESTADO'(SEMILLA);
    localparam logic [BITS_RESULTADO-1:0] P_MIN    = BITS_RESULTADO'(POS_MIN);
    localparam logic [BITS_RESULTADO-1:0] SPAN     = BITS_RESULTADO'(POS_MAX - POS_MIN);
    localparam logic [BITS_RESULTADO:0]   RANGO    = (BITS_RESULTADO+1)'(POS_MAX - POS_MIN + 1);
    localparam logic [BITS_INT-1:0]       ULTIMO   = BITS_INT'(MAX_INTENTOS - 1);

    logic [BITS_ESTADO-1:0]    r_estado;
    fsm_t                      r_fsm;
    logic [BITS_INT-1:0]       r_intentos;
    logic [BITS_RESULTADO-1:0] r_dato;
    logic                      r_forzado;
    logic                      r_valido;
    logic                      r_ocupado;

    logic [2*BITS_ESTADO-1:0]  w_producto;
    logic [BITS_ESTADO-1:0]    w_siguiente;
    logic [BITS_RESULTADO-1:0] w_cand;
    logic [BITS_RESULTADO-1:0] w_desplazado;
    logic                      w_en_rango;
    logic [BITS_RESULTADO:0]   w_resto;
    logic [BITS_RESULTADO-1:0] w_dato_fallback;

    fsm_t                      w_fsm_sig;
    logic [BITS_INT-1:0]       w_intentos_sig;
    logic [BITS_RESULTADO-1:0] w_dato_sig;
    logic                      w_forzado_sig;

    // Full-width product, truncated afterwards so wrap-around is exact modulo 2^BITS_ESTADO.
    assign w_producto  = {{BITS_ESTADO{1'b0}}, MULT} * {{BITS_ESTADO{1'b0}}, r_estado};
    assign w_siguiente = BITS_ESTADO'(w_producto + INC);

    assign w_cand          = r_estado[BITS_ESTADO-1 -: BITS_RESULTADO];
    assign w_desplazado    = w_cand - P_MIN;
    assign w_en_rango      = (w_desplazado <= SPAN);
    assign w_resto         = {1'b0, w_cand} % RANGO;
    assign w_dato_fallback = BITS_RESULTADO'({1'b0, P_MIN} + w_resto);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else if (carga_semilla) begin
            r_estado <= semilla;
        end else begin
            r_estado <= w_siguiente;
        end
    end

    always_comb begin
        w_fsm_sig      = r_fsm;
        w_intentos_sig = r_intentos;
        w_dato_sig     = r_dato;
        w_forzado_sig  = r_forzado;
        case (r_fsm)
            REPOSO: begin
                if (pedir) begin
                    w_fsm_sig      = BUSCANDO;
                    w_intentos_sig = '0;
                end
            end
            BUSCANDO: begin
                if (w_en_rango) begin
                    w_dato_sig    = w_cand;
                    w_forzado_sig = 1'b0;
                    w_fsm_sig     = LISTO;
                end else if (r_intentos == ULTIMO) begin
                    w_dato_sig    = w_dato_fallback;
                    w_forzado_sig = 1'b1;
                    w_fsm_sig     = LISTO;
                end else begin
                    w_intentos_sig = r_intentos + BITS_INT'(1);
                end
            end
            LISTO: begin
                if (tomar) begin
                    w_fsm_sig = REPOSO;
                end
            end
            default: begin
                w_fsm_sig = REPOSO;
            end
        endcase
    end

    // Status flags are registered copies of the next state so they carry no decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm      <= REPOSO;
            r_intentos <= '0;
            r_dato     <= '0;
            r_forzado  <= 1'b0;
            r_valido   <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_sig;
            r_intentos <= w_intentos_sig;
            r_dato     <= w_dato_sig;
            r_forzado  <= w_forzado_sig;
            r_valido   <= (w_fsm_sig == LISTO);
            r_ocupado  <= (w_fsm_sig == BUSCANDO);
        end
    end

    assign dato    = r_dato;
    assign valido  = r_valido;
    assign ocupado = r_ocupado;
    assign forzado = r_forzado;

endmodule

// File: tb/tb_gen_posic_random_rango.sv
// Directed bench on a 4-bit LCG (x' = 5x+3 mod 16, seed 0: 0,3,2,13,4,7,6,1,8,11,10,5,12,15,14,9).
// Three instances share stimulus: full window, window 4..7, and window 8..9 with two attempts.
module tb_gen_posic_random_rango;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pedir = 1'b0;
    logic       tomar = 1'b0;
    logic       carga_semilla = 1'b0;
    logic [3:0] semilla = 4'd0;

    logic [3:0] dato_a, dato_b, dato_c;
    logic       valido_a, valido_b, valido_c;
    logic       ocupado_a, ocupado_b, ocupado_c;
    logic       forzado_a, forzado_b, forzado_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen_posic_random_rango #(.BITS_ESTADO(4), .BITS_RESULTADO(4), .SEMILLA(0), .MULTIPLICADOR(5),
        .CONSTANTE_ADITIVA(3), .POS_MIN(0), .POS_MAX(15), .MAX_INTENTOS(8)) dut_a (
        .clk(clk), .reset(reset), .pedir(pedir), .tomar(tomar), .carga_semilla(carga_semilla),
        .semilla(semilla), .dato(dato_a), .valido(valido_a), .ocupado(ocupado_a), .forzado(forzado_a));

    gen_posic_random_rango #(.BITS_ESTADO(4), .BITS_RESULTADO(4), .SEMILLA(0), .MULTIPLICADOR(5),
        .CONSTANTE_ADITIVA(3), .POS_MIN(4), .POS_MAX(7), .MAX_INTENTOS(8)) dut_b (
        .clk(clk), .reset(reset), .pedir(pedir), .tomar(tomar), .carga_semilla(carga_semilla),
        .semilla(semilla), .dato(dato_b), .valido(valido_b), .ocupado(ocupado_b), .forzado(forzado_b));

    gen_posic_random_rango #(.BITS_ESTADO(4), .BITS_RESULTADO(4), .SEMILLA(0), .MULTIPLICADOR(5),
        .CONSTANTE_ADITIVA(3), .POS_MIN(8), .POS_MAX(9), .MAX_INTENTOS(2)) dut_c (
        .clk(clk), .reset(reset), .pedir(pedir), .tomar(tomar), .carga_semilla(carga_semilla),
        .semilla(semilla), .dato(dato_c), .valido(valido_c), .ocupado(ocupado_c), .forzado(forzado_c));

    // Holds reset for two cycles and releases it at a falling edge; with_pedir makes the next rising edge "edge 1" of a request.
    task automatic do_reset(input logic with_pedir);
        reset = 1'b1;
        tomar = 1'b0;
        carga_semilla = 1'b0;
        pedir = 1'b0;
        repeat (2) @(negedge clk);
        pedir = with_pedir;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++;
        if ({dato_a, valido_a, ocupado_a, forzado_a} !== 7'd0) begin
            errors++;
            $display("FAIL reset_a got dato=%0d val=%b ocu=%b frz=%b want all 0", dato_a, valido_a, ocupado_a, forzado_a);
        end
        checks++;
        if ({dato_c, valido_c, ocupado_c, forzado_c} !== 7'd0) begin
            errors++;
            $display("FAIL reset_c got dato=%0d val=%b ocu=%b frz=%b want all 0", dato_c, valido_c, ocupado_c, forzado_c);
        end
    endtask

    task automatic test_full_window();
        do_reset(1'b1);
        @(negedge clk);
        pedir = 1'b0;
        checks++;
        if (ocupado_a !== 1'b1 || valido_a !== 1'b0) begin
            errors++;
            $display("FAIL full_edge1 got ocu=%b val=%b want ocu=1 val=0", ocupado_a, valido_a);
        end
        @(negedge clk);
        checks++;
        if (dato_a !== 4'd3 || valido_a !== 1'b1 || forzado_a !== 1'b0 || ocupado_a !== 1'b0) begin
            errors++;
            $display("FAIL full_edge2 got dato=%0d val=%b frz=%b ocu=%b want 3 1 0 0", dato_a, valido_a, forzado_a, ocupado_a);
        end
    endtask

    task automatic test_rejection();
        do_reset(1'b1);
        @(negedge clk);
        pedir = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (valido_b !== 1'b0 || ocupado_b !== 1'b1) begin
            errors++;
            $display("FAIL reject_edge4 got val=%b ocu=%b want val=0 ocu=1", valido_b, ocupado_b);
        end
        @(negedge clk);
        checks++;
        if (dato_b !== 4'd4 || valido_b !== 1'b1 || forzado_b !== 1'b0 || ocupado_b !== 1'b0) begin
            errors++;
            $display("FAIL reject_edge5 got dato=%0d val=%b frz=%b ocu=%b want 4 1 0 0", dato_b, valido_b, forzado_b, ocupado_b);
        end
    endtask

    task automatic test_fallback();
        do_reset(1'b1);
        @(negedge clk);
        pedir = 1'b0;
        @(negedge clk);
        checks++;
        if (valido_c !== 1'b0 || ocupado_c !== 1'b1) begin
            errors++;
            $display("FAIL fallback_edge2 got val=%b ocu=%b want val=0 ocu=1", valido_c, ocupado_c);
        end
        @(negedge clk);
        checks++;
        if (dato_c !== 4'd8 || valido_c !== 1'b1 || forzado_c !== 1'b1) begin
            errors++;
            $display("FAIL fallback_edge3 got dato=%0d val=%b frz=%b want 8 1 1", dato_c, valido_c, forzado_c);
        end
    endtask

    task automatic test_seed();
        do_reset(1'b1);
        carga_semilla = 1'b1;
        semilla = 4'd8;
        @(negedge clk);
        pedir = 1'b0;
        carga_semilla = 1'b0;
        @(negedge clk);
        checks++;
        if (dato_a !== 4'd8 || valido_a !== 1'b1 || forzado_a !== 1'b0) begin
            errors++;
            $display("FAIL seed got dato=%0d val=%b frz=%b want 8 1 0", dato_a, valido_a, forzado_a);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset(1'b1);
        @(negedge clk);
        pedir = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            pedir = i[0];
            @(negedge clk);
            if (dato_a !== 4'd3 || valido_a !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_listo got %0d unstable cycles want 0 (last dato=%0d val=%b)", bad, dato_a, valido_a);
        end
        tomar = 1'b1;
        pedir = 1'b1;
        @(negedge clk);
        tomar = 1'b0;
        pedir = 1'b0;
        checks++;
        if (valido_a !== 1'b0 || dato_a !== 4'd3) begin
            errors++;
            $display("FAIL take got val=%b dato=%0d want val=0 dato=3", valido_a, dato_a);
        end
        @(negedge clk);
        checks++;
        if (valido_a !== 1'b0 || ocupado_a !== 1'b0) begin
            errors++;
            $display("FAIL dropped_pedir got val=%b ocu=%b want 0 0", valido_a, ocupado_a);
        end
        pedir = 1'b1;
        @(negedge clk);
        pedir = 1'b0;
        checks++;
        if (ocupado_a !== 1'b1) begin
            errors++;
            $display("FAIL rerequest_busy got ocu=%b want 1", ocupado_a);
        end
        @(negedge clk);
        checks++;
        if (dato_a !== 4'd9 || valido_a !== 1'b1 || forzado_a !== 1'b0) begin
            errors++;
            $display("FAIL rerequest got dato=%0d val=%b frz=%b want 9 1 0", dato_a, valido_a, forzado_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        @(negedge clk);
        pedir = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ocupado_b !== 1'b1 || valido_a !== 1'b1 || forzado_c !== 1'b1) begin
            errors++;
            $display("FAIL pre_async got ocu_b=%b val_a=%b frz_c=%b want 1 1 1", ocupado_b, valido_a, forzado_c);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dato_a, valido_a, forzado_a} !== 6'd0 || ocupado_b !== 1'b0 || {dato_c, forzado_c, valido_c} !== 6'd0) begin
            errors++;
            $display("FAIL async_reset got dato_a=%0d val_a=%b ocu_b=%b dato_c=%0d frz_c=%b want all 0",
                     dato_a, valido_a, ocupado_b, dato_c, forzado_c);
        end
        do_reset(1'b1);
        @(negedge clk);
        pedir = 1'b0;
        @(negedge clk);
        checks++;
        if (dato_a !== 4'd3 || valido_a !== 1'b1) begin
            errors++;
            $display("FAIL after_async got dato=%0d val=%b want 3 1", dato_a, valido_a);
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_rejection();
        test_fallback();
        test_seed();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_posic_random_rango.md
Name: gen_posic_random_rango

Overview:
- Parametrised successor to the single-LCG position generator used for alien and bonus-ship spawn positions.
- Runs a free-running linear congruential generator (LCG) of configurable width with a runtime reseed input.
- Maps the LCG output into a configurable window [POS_MIN, POS_MAX] by rejection sampling. A bounded fallback guarantees a result.
- Delivers each position over a request/valid/accept handshake, so game-control FSMs get one fresh, stable value per request.

Parameters:
- BITS_ESTADO, 16: LCG state width; arithmetic is modulo 2^BITS_ESTADO.
- BITS_RESULTADO, 11: output position width; must satisfy BITS_RESULTADO <= BITS_ESTADO.
- SEMILLA, 1: state value loaded on reset.
- MULTIPLICADOR, 25173: LCG multiplier.
- CONSTANTE_ADITIVA, 13849: LCG increment.
- POS_MIN, 0: lowest accepted position.
- POS_MAX, 639: highest accepted position; must satisfy POS_MIN <= POS_MAX < 2^BITS_RESULTADO.
- MAX_INTENTOS, 8: candidates examined before fallback; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- pedir  in  1  request a new position; sampled only in REPOSO
- tomar  in  1  consumer accepts dato; sampled only in LISTO
- carga_semilla  in  1  load semilla into LCG state this edge
- semilla  in  BITS_ESTADO  reseed value
- dato  out  BITS_RESULTADO  delivered position; stable while valido=1
- valido  out  1  dato holds an unconsumed result
- ocupado  out  1  high in BUSCANDO
- forzado  out  1  qualifies dato: 1 when produced by the fallback path

Behaviour:
- Reset: asynchronous, takes effect immediately.
  - estado=SEMILLA, FSM=REPOSO, intentos=0.
  - dato=0, valido=0, ocupado=0, forzado=0.
- LCG, every clock edge, independent of FSM state:
  - If carga_semilla=1: estado <= semilla.
  - Otherwise: estado <= (MULTIPLICADOR*estado + CONSTANTE_ADITIVA) mod 2^BITS_ESTADO. Compute the product at full width, then truncate.
- Candidate: cand = estado[BITS_ESTADO-1 -: BITS_RESULTADO] (the upper bits of the registered state).
- FSM states: REPOSO, BUSCANDO, LISTO.
  - REPOSO: when pedir=1, go to BUSCANDO and clear intentos.
  - BUSCANDO, in-range candidate (POS_MIN <= cand <= POS_MAX):
    - dato <= cand, forzado <= 0, go to LISTO.
  - BUSCANDO, out-of-range candidate, intentos == MAX_INTENTOS-1:
    - dato <= POS_MIN + (cand mod (POS_MAX-POS_MIN+1)), forzado <= 1, go to LISTO.
  - BUSCANDO, out-of-range candidate, otherwise:
    - intentos <= intentos+1, stay in BUSCANDO.
  - LISTO: when tomar=1, go to REPOSO.
    - valido falls on that edge.
    - dato and forzado keep their last value.
- Outputs are registered: valido=1 exactly in LISTO; ocupado=1 exactly in BUSCANDO.
- Latency: pedir sampled at edge N gives valido=1 after edge N+1+k, where k = number of rejected candidates. Minimum is 2 edges; maximum is MAX_INTENTOS+1 edges.
- Boundary rules:
  - pedir in BUSCANDO or LISTO is ignored and is not queued.
  - pedir and tomar both high in LISTO: tomar is honoured, pedir is dropped. The requester must reassert pedir in REPOSO.
  - tomar outside LISTO is ignored.
  - carga_semilla during BUSCANDO: that edge still evaluates the old registered cand. Subsequent candidates come from the new seed. intentos is not cleared.
  - Full window (POS_MIN=0, POS_MAX=2^BITS_RESULTADO-1): never rejects, and forzado is always 0.
  - State wraps modulo 2^BITS_ESTADO with no saturation.

Test Plan (small configuration: BITS_ESTADO=4, BITS_RESULTADO=4, MULTIPLICADOR=5, CONSTANTE_ADITIVA=3, SEMILLA=0, giving the LCG sequence 0,3,2,13,4,7,6,1,8,...):
- Full window (0..15), pedir=1 at the first edge after reset -> dato=3, valido=1, forzado=0 after the 2nd edge; ocupado=1 for exactly 1 cycle.
- Window 4..7, MAX_INTENTOS=8, pedir at edge 1 -> candidates 3, 2, 13 rejected; dato=4 with valido=1 after edge 5; forzado=0.
- Window 8..9, MAX_INTENTOS=2, pedir at edge 1 -> candidates 3 then 2 rejected; dato=8+(2 mod 2)=8, forzado=1, valido=1 after edge 3.
- Full window, carga_semilla=1 with semilla=8 and pedir=1 on the same edge 1 -> dato=8 after edge 2.
- Handshake: hold tomar=0 for 10 cycles in LISTO and pulse pedir -> dato and valido unchanged. Pulse tomar -> valido=0 next cycle. A new pedir then yields a new value.
- Assert reset asynchronously mid-BUSCANDO (between clock edges) -> valido, ocupado, forzado and dato go to 0 immediately; after release, the first request returns dato=3 again.
